// File: rtl/traffic_pkg.sv
// Shared lamp encodings, FSM state codes and lamp decode helpers for the junction controller.
// No timing or flow control of its own; pure types and combinational functions.
package traffic_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_t;

    typedef enum logic [STATE_W-1:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_CG  = 3'd3,
        S_CY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    // Illegal codes decode to all-red so a corrupted register can never show two non-red roads.
    function automatic lamp_t hwy_lamp(input state_t s);
        case (s)
            S_HG:    return GREEN;
            S_HY:    return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic lamp_t ctry_lamp(input state_t s);
        case (s)
            S_CG:    return GREEN;
            S_CY:    return YELLOW;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_sig_ctrl_param_if.sv
// Sensor inputs and lamp/status outputs of one junction controller.
// slave = controller side, master = sensor/lamp-driver side; no handshake, level signals only.
interface traffic_sig_ctrl_param_if;
    import traffic_pkg::*;

    logic                 X;
    logic                 EMERG;
    lamp_t                HIGHWAY;
    lamp_t                COUNTRY;
    logic [STATE_W-1:0]   STATE;
    logic                 TIMEOUT;

    modport master (
        output X,
        output EMERG,
        input  HIGHWAY,
        input  COUNTRY,
        input  STATE,
        input  TIMEOUT
    );

    modport slave (
        input  X,
        input  EMERG,
        output HIGHWAY,
        output COUNTRY,
        output STATE,
        output TIMEOUT
    );

endinterface

// File: rtl/sig_phase_timer.sv
// Per-state cycle counter: cleared on restart, otherwise +1 per cycle, optionally saturating at limit.
// at_limit is a combinational compare of the registered count; no backpressure.
module sig_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             restart,
    input  logic             hold_at_limit,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt;

    // >= rather than == keeps the compare safe if cnt ever lands above the limit.
    assign at_limit = (cnt >= limit);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (hold_at_limit && at_limit) begin
            cnt <= cnt;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_sig_ctrl_param.sv
// Highway/country junction Moore FSM with counter-timed yellow/all-red, min highway green, capped country green.
// Lamps and STATE decode the state register; TIMEOUT is registered; sensors are level inputs, no backpressure.
module traffic_sig_ctrl_param
    import traffic_pkg::*;
#(
    parameter int YTOR_DELAY     = 3,
    parameter int RTOG_DELAY     = 2,
    parameter int MIN_HWY_GREEN  = 8,
    parameter int MAX_CTRY_GREEN = 16,
    parameter int CNT_W          = 5
) (
    input  logic                     clock,
    input  logic                     clear,
    traffic_sig_ctrl_param_if.slave  road
);

    localparam logic [CNT_W-1:0] HG_LIM = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] YR_LIM = CNT_W'(YTOR_DELAY - 1);
    localparam logic [CNT_W-1:0] RG_LIM = CNT_W'(RTOG_DELAY - 1);
    localparam logic [CNT_W-1:0] CG_LIM = CNT_W'(MAX_CTRY_GREEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic             timeout_q;
    logic             timeout_nxt;
    logic [CNT_W-1:0] limit;
    logic             at_limit;
    logic             restart;
    logic             hold_at_limit;

    always_comb begin
        limit = '0;
        case (state)
            S_HG:        limit = HG_LIM;
            S_HY, S_CY:  limit = YR_LIM;
            S_AR1, S_AR2: limit = RG_LIM;
            S_CG:        limit = CG_LIM;
            default:     limit = '0;
        endcase
    end

    // Highway green waits indefinitely for a car, so its count parks at the minimum.
    assign hold_at_limit = (state == S_HG);
    assign restart       = (state_nxt != state);

    sig_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock         (clock),
        .clear         (clear),
        .restart       (restart),
        .hold_at_limit (hold_at_limit),
        .limit         (limit),
        .at_limit      (at_limit)
    );

    always_comb begin
        state_nxt   = state;
        timeout_nxt = 1'b0;
        case (state)
            S_HG:  if (road.X && !road.EMERG && at_limit) state_nxt = S_HY;
            S_HY:  if (at_limit) state_nxt = S_AR1;
            S_AR1: if (at_limit) state_nxt = S_CG;
            S_CG: begin
                // TIMEOUT only when the cap alone ended green; a drop of X or EMERG wins the tie.
                if (!road.X || road.EMERG || at_limit) begin
                    state_nxt   = S_CY;
                    timeout_nxt = at_limit && road.X && !road.EMERG;
                end
            end
            S_CY:  if (at_limit) state_nxt = S_AR2;
            S_AR2: if (at_limit) state_nxt = S_HG;
            default: state_nxt = S_HG;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= S_HG;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign road.HIGHWAY = hwy_lamp(state);
    assign road.COUNTRY = ctry_lamp(state);
    assign road.STATE   = state;
    assign road.TIMEOUT = timeout_q;

endmodule
